// File: rtl/rom_arb_pkg.sv
// Shared types and default constants for the Freeze ROM port arbiter.
// Imported by the round-robin picker and the arbiter top.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        G_NONE,
        G_WR,
        G_GFX,
        G_MCPU,
        G_SCPU
    } gnt_t;

    localparam int          DEF_AW        = 22;
    localparam logic [21:0] DEF_MCPU_BASE = 22'h000000;
    localparam logic [21:0] DEF_SCPU_BASE = 22'h008000;
    localparam logic [21:0] DEF_GFX_BASE  = 22'h010000;

    // Pick the byte lane a Z80 fetch wants out of a 16-bit ROM word.
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin picker between the main and sound CPU fetch requests.
// The pointer remembers which CPU was served last; on a tie the other one wins.
module rom_arb_rr
    import rom_arb_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic mreq_i,
    input  logic sreq_i,
    input  logic upd_i,
    input  logic upd_scpu_i,
    output logic gnt_m_o,
    output logic gnt_s_o
);

    // 1: sound CPU was granted last, so the main CPU is favoured
    logic last_s_q;
    logic last_s_d;

    always_comb begin
        gnt_m_o  = mreq_i && (!sreq_i || last_s_q);
        gnt_s_o  = sreq_i && (!mreq_i || !last_s_q);
        last_s_d = upd_i ? upd_scpu_i : last_s_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            last_s_q <= 1'b1;
        end else begin
            last_s_q <= last_s_d;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single 16-bit ROM port between download writes, the graphics
// fetcher and byte fetches from the main and sound Z80s, one transaction at a time.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int            AW        = DEF_AW,
    parameter logic [AW-1:0] MCPU_BASE = DEF_MCPU_BASE,
    parameter logic [AW-1:0] SCPU_BASE = DEF_SCPU_BASE,
    parameter logic [AW-1:0] GFX_BASE  = DEF_GFX_BASE
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [26:0]   ioctl_addr,
    input  logic [15:0]   ioctl_dout,
    input  logic          ioctl_wr,
    input  logic          gfx_req,
    input  logic [13:0]   gfx_addr,
    output logic          gfx_ack,
    output logic [15:0]   gfx_data,
    input  logic          mcpu_req,
    input  logic [15:0]   mcpu_addr,
    output logic          mcpu_ack,
    output logic [7:0]    mcpu_data,
    input  logic          scpu_req,
    input  logic [15:0]   scpu_addr,
    output logic          scpu_ack,
    output logic [7:0]    scpu_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_dout,
    input  logic          mem_rdy,
    input  logic [15:0]   mem_din,
    output logic          dl_overflow
);

    state_t        state_q;
    gnt_t          gnt_q;
    gnt_t          gnt_d;
    logic          wr_pend_q;
    logic [AW-1:0] wr_addr_q;
    logic [15:0]   wr_data_q;
    logic          dl_overflow_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] mem_addr_d;
    logic [15:0]   mem_dout_q;
    logic          byte_hi_q;
    logic          byte_hi_d;
    logic          gfx_ack_q;
    logic [15:0]   gfx_data_q;
    logic          mcpu_ack_q;
    logic [7:0]    mcpu_data_q;
    logic          scpu_ack_q;
    logic [7:0]    scpu_data_q;

    logic          rr_gnt_m;
    logic          rr_gnt_s;
    logic          rr_upd;
    logic          wr_done;

    logic [AW-1:0] gfx_waddr;
    logic [AW-1:0] mcpu_waddr;
    logic [AW-1:0] scpu_waddr;
    logic [AW-1:0] dl_waddr;
    logic          unused_ioctl_bits;

    assign gfx_waddr  = GFX_BASE  + AW'(gfx_addr);
    assign mcpu_waddr = MCPU_BASE + AW'(mcpu_addr[15:1]);
    assign scpu_waddr = SCPU_BASE + AW'(scpu_addr[15:1]);
    assign dl_waddr   = ioctl_addr[AW:1];
    assign unused_ioctl_bits = ^{ioctl_addr[26:AW+1], ioctl_addr[0]};

    assign wr_done = (state_q == DONE) && (gnt_q == G_WR);
    assign rr_upd  = (state_q == DONE) && ((gnt_q == G_MCPU) || (gnt_q == G_SCPU));

    rom_arb_rr u_rr (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .mreq_i     (mcpu_req),
        .sreq_i     (scpu_req),
        .upd_i      (rr_upd),
        .upd_scpu_i (gnt_q == G_SCPU),
        .gnt_m_o    (rr_gnt_m),
        .gnt_s_o    (rr_gnt_s)
    );

    // Reads are held off entirely while a download is streaming in.
    always_comb begin
        gnt_d = G_NONE;
        if (wr_pend_q) begin
            gnt_d = G_WR;
        end else if (!ioctl_download) begin
            if (gfx_req)       gnt_d = G_GFX;
            else if (rr_gnt_m) gnt_d = G_MCPU;
            else if (rr_gnt_s) gnt_d = G_SCPU;
        end

        mem_addr_d = '0;
        byte_hi_d  = 1'b0;
        case (gnt_d)
            G_WR:   mem_addr_d = wr_addr_q;
            G_GFX:  mem_addr_d = gfx_waddr;
            G_MCPU: begin
                mem_addr_d = mcpu_waddr;
                byte_hi_d  = mcpu_addr[0];
            end
            G_SCPU: begin
                mem_addr_d = scpu_waddr;
                byte_hi_d  = scpu_addr[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= G_NONE;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            dl_overflow_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_dout_q    <= '0;
            byte_hi_q     <= 1'b0;
            gfx_ack_q     <= 1'b0;
            gfx_data_q    <= '0;
            mcpu_ack_q    <= 1'b0;
            mcpu_data_q   <= '0;
            scpu_ack_q    <= 1'b0;
            scpu_data_q   <= '0;
        end else begin
            gfx_ack_q  <= 1'b0;
            mcpu_ack_q <= 1'b0;
            scpu_ack_q <= 1'b0;

            // A write landing on the cycle the old one retires is still accepted.
            if (ioctl_wr) begin
                if (wr_pend_q && !wr_done) begin
                    dl_overflow_q <= 1'b1;
                end else begin
                    wr_pend_q <= 1'b1;
                    wr_addr_q <= dl_waddr;
                    wr_data_q <= ioctl_dout;
                end
            end else if (wr_done) begin
                wr_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (gnt_d != G_NONE) begin
                        gnt_q      <= gnt_d;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= (gnt_d == G_WR);
                        mem_addr_q <= mem_addr_d;
                        mem_dout_q <= (gnt_d == G_WR) ? wr_data_q : 16'h0000;
                        byte_hi_q  <= byte_hi_d;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        case (gnt_q)
                            G_GFX: begin
                                gfx_ack_q  <= 1'b1;
                                gfx_data_q <= mem_din;
                            end
                            G_MCPU: begin
                                mcpu_ack_q  <= 1'b1;
                                mcpu_data_q <= byte_sel(mem_din, byte_hi_q);
                            end
                            G_SCPU: begin
                                scpu_ack_q  <= 1'b1;
                                scpu_data_q <= byte_sel(mem_din, byte_hi_q);
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    gnt_q   <= G_NONE;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gfx_ack     = gfx_ack_q;
    assign gfx_data    = gfx_data_q;
    assign mcpu_ack    = mcpu_ack_q;
    assign mcpu_data   = mcpu_data_q;
    assign scpu_ack    = scpu_ack_q;
    assign scpu_data   = scpu_data_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_dout    = mem_dout_q;
    assign dl_overflow = dl_overflow_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed scenarios plus a randomized requester/memory soak for rom_arbiter,
// checked against a transaction-level model of the arbitration rules.
module tb_rom_arbiter;

    localparam int AW = 22;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic [26:0]   ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          ioctl_wr;
    logic          gfx_req;
    logic [13:0]   gfx_addr;
    logic          gfx_ack;
    logic [15:0]   gfx_data;
    logic          mcpu_req;
    logic [15:0]   mcpu_addr;
    logic          mcpu_ack;
    logic [7:0]    mcpu_data;
    logic          scpu_req;
    logic [15:0]   scpu_addr;
    logic          scpu_ack;
    logic [7:0]    scpu_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_dout;
    logic          mem_rdy;
    logic [15:0]   mem_din;
    logic          dl_overflow;

    always #5 clk_sys = ~clk_sys;

    rom_arbiter dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .gfx_req        (gfx_req),
        .gfx_addr       (gfx_addr),
        .gfx_ack        (gfx_ack),
        .gfx_data       (gfx_data),
        .mcpu_req       (mcpu_req),
        .mcpu_addr      (mcpu_addr),
        .mcpu_ack       (mcpu_ack),
        .mcpu_data      (mcpu_data),
        .scpu_req       (scpu_req),
        .scpu_addr      (scpu_addr),
        .scpu_ack       (scpu_ack),
        .scpu_data      (scpu_data),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_rdy        (mem_rdy),
        .mem_din        (mem_din),
        .dl_overflow    (dl_overflow)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory responder and event log
    int            rsp_wait = 0;
    logic          rsp_rand = 1'b0;
    logic [15:0]   rsp_din  = 16'h0000;
    logic [15:0]   last_din = 16'h0000;
    int            rsp_cnt;
    logic          rsp_busy;
    logic          rsp_req_d;
    int            ack_m = 0;
    int            ack_s = 0;
    int            ack_g = 0;
    int            ack_q[$];
    logic [AW-1:0] gnt_addr_q[$];
    logic [AW-1:0] wlog_addr[$];
    logic [15:0]   wlog_data[$];

    initial begin
        mem_rdy   = 1'b0;
        mem_din   = 16'h0000;
        rsp_busy  = 1'b0;
        rsp_cnt   = 0;
        rsp_req_d = 1'b0;
        forever begin
            @(negedge clk_sys);
            mem_rdy = 1'b0;
            if (mem_req && !rsp_req_d) gnt_addr_q.push_back(mem_addr);
            if (gfx_ack)  begin ack_g++; ack_q.push_back(0); end
            if (mcpu_ack) begin ack_m++; ack_q.push_back(1); end
            if (scpu_ack) begin ack_s++; ack_q.push_back(2); end
            if (!mem_req) begin
                rsp_busy = 1'b0;
            end else if (!rsp_busy) begin
                rsp_busy = 1'b1;
                rsp_cnt  = rsp_rand ? int'($urandom_range(0, 3)) : rsp_wait;
            end
            if (rsp_busy && rsp_cnt == 0) begin
                mem_rdy  = 1'b1;
                mem_din  = rsp_rand ? 16'($urandom) : rsp_din;
                last_din = mem_din;
                rsp_busy = 1'b0;
                if (mem_we) begin
                    wlog_addr.push_back(mem_addr);
                    wlog_data.push_back(mem_dout);
                end
            end else if (rsp_busy) begin
                rsp_cnt--;
            end
            rsp_req_d = mem_req;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic dl_write(input logic [26:0] a, input logic [15:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    // Randomized phase state
    logic        a_req[3];
    logic        a_ack[3];
    logic [15:0] a_addr[3];
    int          a_gap[3];
    int          a_age[3];
    int          max_age;
    logic        last_s;
    logic        outst;
    logic        rq_d;
    logic        exp_hi;
    int          exp_who;
    int          w;
    logic [31:0] ea;
    int          snap;

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;
        gfx_req = 1'b0; gfx_addr = '0; mcpu_req = 1'b0; mcpu_addr = '0;
        scpu_req = 1'b0; scpu_addr = '0;
        repeat (3) @(negedge clk_sys);

        chk("rst_mem_req",  32'(mem_req), 0);
        chk("rst_mem_we",   32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_dout", 32'(mem_dout), 0);
        chk("rst_acks",     32'({gfx_ack, mcpu_ack, scpu_ack}), 0);
        chk("rst_data",     32'({gfx_data, mcpu_data, scpu_data}), 0);
        chk("rst_overflow", 32'(dl_overflow), 0);
        reset = 1'b0;

        // Single main-CPU fetch, zero-wait memory
        rsp_wait = 0; rsp_din = 16'hBEEF;
        @(negedge clk_sys);
        mcpu_addr = 16'h0003; mcpu_req = 1'b1;
        @(negedge clk_sys);
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_addr", 32'(mem_addr), 1);
        chk("t1_mem_we", 32'(mem_we), 0);
        chk("t1_ack_early", 32'(mcpu_ack), 0);
        @(negedge clk_sys);
        chk("t1_ack", 32'(mcpu_ack), 1);
        chk("t1_data", 32'(mcpu_data), 32'h0BE);
        mcpu_req = 1'b0;
        @(negedge clk_sys);
        chk("t1_ack_pulse", 32'(mcpu_ack), 0);
        repeat (3) @(negedge clk_sys);

        // Both CPUs requesting continuously: alternate starting with mcpu
        pulse_reset();
        ack_q.delete();
        mcpu_addr = 16'h0010; scpu_addr = 16'h0021;
        mcpu_req = 1'b1; scpu_req = 1'b1;
        for (int i = 0; i < 60 && ack_q.size() < 4; i++) @(negedge clk_sys);
        mcpu_req = 1'b0; scpu_req = 1'b0;
        chk("t2_ack_count", 32'(ack_q.size()), 4);
        if (ack_q.size() >= 4) begin
            chk("t2_order0", 32'(ack_q[0]), 1);
            chk("t2_order1", 32'(ack_q[1]), 2);
            chk("t2_order2", 32'(ack_q[2]), 1);
            chk("t2_order3", 32'(ack_q[3]), 2);
        end
        chk("t2_scpu_data", 32'(scpu_data), 32'h0BE);
        chk("t2_mcpu_data", 32'(mcpu_data), 32'h0EF);
        repeat (6) @(negedge clk_sys);

        // gfx outranks both CPUs
        pulse_reset();
        ack_q.delete(); gnt_addr_q.delete();
        gfx_addr = 14'h0010;
        gfx_req = 1'b1; mcpu_req = 1'b1; scpu_req = 1'b1;
        for (int i = 0; i < 30 && gfx_req; i++) begin
            @(negedge clk_sys);
            if (gfx_ack) gfx_req = 1'b0;
        end
        chk("t3_gfx_acked", 32'(gfx_req), 0);
        for (int i = 0; i < 40 && ack_q.size() < 3; i++) @(negedge clk_sys);
        mcpu_req = 1'b0; scpu_req = 1'b0;
        repeat (8) @(negedge clk_sys);
        if (gnt_addr_q.size() >= 2 && ack_q.size() >= 3) begin
            chk("t3_first_addr", 32'(gnt_addr_q[0]), 32'h010010);
            chk("t3_second_addr", 32'(gnt_addr_q[1]), 32'h000008);
            chk("t3_first_ack", 32'(ack_q[0]), 0);
            chk("t3_second_ack", 32'(ack_q[1]), 1);
            chk("t3_third_ack", 32'(ack_q[2]), 2);
        end else begin
            chk("t3_grants_seen", 32'(ack_q.size()), 3);
        end
        chk("t3_gfx_data_held", 32'(gfx_data), 32'hBEEF);

        // Download at 4-cycle spacing while mcpu waits
        ioctl_download = 1'b1;
        mcpu_addr = 16'h0004; mcpu_req = 1'b1;
        snap = ack_m;
        wlog_addr.delete(); wlog_data.delete();
        for (int i = 0; i < 3; i++) begin
            dl_write(27'(2 * i), 16'h1100 + 16'(i));
            repeat (3) @(negedge clk_sys);
        end
        repeat (4) @(negedge clk_sys);
        chk("t4_write_count", 32'(wlog_addr.size()), 3);
        for (int i = 0; i < 3 && i < wlog_addr.size(); i++) begin
            chk("t4_write_addr", 32'(wlog_addr[i]), 32'(i));
            chk("t4_write_data", 32'(wlog_data[i]), 32'h1100 + 32'(i));
        end
        chk("t4_overflow", 32'(dl_overflow), 0);
        chk("t4_no_cpu_ack", 32'(ack_m), 32'(snap));
        ioctl_download = 1'b0;
        for (int i = 0; i < 10 && mcpu_req; i++) begin
            @(negedge clk_sys);
            if (mcpu_ack) mcpu_req = 1'b0;
        end
        chk("t4_cpu_after_dl", 32'(mcpu_req), 0);
        repeat (3) @(negedge clk_sys);

        // Write arriving in the cycle the previous one retires
        pulse_reset();
        ioctl_download = 1'b1;
        wlog_addr.delete(); wlog_data.delete();
        dl_write(27'd20, 16'hC0DE);
        repeat (2) @(negedge clk_sys);
        dl_write(27'd22, 16'hD00D);
        repeat (6) @(negedge clk_sys);
        chk("t4b_write_count", 32'(wlog_addr.size()), 2);
        if (wlog_addr.size() >= 2) begin
            chk("t4b_addr1", 32'(wlog_addr[1]), 32'd11);
            chk("t4b_data1", 32'(wlog_data[1]), 32'hD00D);
        end
        chk("t4b_overflow", 32'(dl_overflow), 0);

        // Back-to-back writes against a stalled memory
        rsp_wait = 5;
        wlog_addr.delete(); wlog_data.delete();
        dl_write(27'd10, 16'hAAAA);
        dl_write(27'd12, 16'hBBBB);
        repeat (12) @(negedge clk_sys);
        chk("t5_write_count", 32'(wlog_addr.size()), 1);
        if (wlog_addr.size() >= 1) begin
            chk("t5_addr", 32'(wlog_addr[0]), 32'd5);
            chk("t5_data", 32'(wlog_data[0]), 32'hAAAA);
        end
        chk("t5_overflow", 32'(dl_overflow), 1);
        repeat (5) @(negedge clk_sys);
        chk("t5_overflow_sticky", 32'(dl_overflow), 1);
        pulse_reset();
        chk("t5_overflow_cleared", 32'(dl_overflow), 0);
        ioctl_download = 1'b0;

        // Reset while a read is stalled in BUSY
        rsp_wait = 20; rsp_din = 16'h1234;
        snap = ack_m;
        mcpu_addr = 16'h0006; mcpu_req = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk_sys);
        chk("t6_busy", 32'(mem_req), 1);
        repeat (2) @(negedge clk_sys);
        reset = 1'b1;
        rsp_wait = 0;
        @(negedge clk_sys);
        chk("t6_req_dropped", 32'(mem_req), 0);
        reset = 1'b0;
        chk("t6_no_ack", 32'(ack_m), 32'(snap));
        for (int i = 0; i < 10 && mcpu_req; i++) begin
            @(negedge clk_sys);
            if (mcpu_ack) begin
                chk("t6_data", 32'(mcpu_data), 32'h034);
                mcpu_req = 1'b0;
            end
        end
        chk("t6_served", 32'(mcpu_req), 0);
        repeat (3) @(negedge clk_sys);

        // Randomized soak: three requesters, random wait states
        rsp_rand = 1'b1;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            a_req[k] = 1'b0; a_addr[k] = '0; a_gap[k] = k; a_age[k] = 0;
        end
        max_age = 0; last_s = 1'b1; outst = 1'b0; rq_d = 1'b0; exp_who = 0; exp_hi = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_sys);
            a_ack[0] = gfx_ack; a_ack[1] = mcpu_ack; a_ack[2] = scpu_ack;

            if (gfx_ack || mcpu_ack || scpu_ack) begin
                chk("rnd_ack_who", 32'({gfx_ack, mcpu_ack, scpu_ack}),
                    outst ? (32'h4 >> exp_who) : 32'h0);
                if (outst && exp_who == 0) chk("rnd_gfx_data", 32'(gfx_data), 32'(last_din));
                if (outst && exp_who == 1)
                    chk("rnd_mcpu_data", 32'(mcpu_data), exp_hi ? 32'(last_din[15:8]) : 32'(last_din[7:0]));
                if (outst && exp_who == 2)
                    chk("rnd_scpu_data", 32'(scpu_data), exp_hi ? 32'(last_din[15:8]) : 32'(last_din[7:0]));
                outst = 1'b0;
            end

            if (mem_req && !rq_d) begin
                if (gfx_req)                   w = 0;
                else if (mcpu_req && scpu_req) w = last_s ? 1 : 2;
                else if (mcpu_req)             w = 1;
                else if (scpu_req)             w = 2;
                else                           w = -1;
                chk("rnd_grant_has_req", 32'(w >= 0), 1);
                if (w == 0)      ea = 32'h10000 + 32'(gfx_addr);
                else if (w == 1) ea = 32'(mcpu_addr) / 2;
                else             ea = 32'h8000 + 32'(scpu_addr) / 2;
                chk("rnd_grant_addr", 32'(mem_addr), ea);
                chk("rnd_grant_we", 32'(mem_we), 0);
                chk("rnd_no_overlap", 32'(outst), 0);
                exp_who = w;
                exp_hi  = (w == 1) ? mcpu_addr[0] : scpu_addr[0];
                outst   = 1'b1;
                if (w == 1) last_s = 1'b0;
                if (w == 2) last_s = 1'b1;
            end
            rq_d = mem_req;

            for (int k = 0; k < 3; k++) begin
                if (a_req[k]) begin
                    a_age[k]++;
                    if (a_age[k] > max_age) max_age = a_age[k];
                    if (a_ack[k]) begin
                        a_req[k] = 1'b0;
                        a_gap[k] = int'($urandom_range(1, 4));
                    end
                end else if (a_gap[k] == 0) begin
                    a_req[k]  = 1'b1;
                    a_addr[k] = 16'($urandom);
                    a_age[k]  = 0;
                end else begin
                    a_gap[k]--;
                end
            end
            gfx_req  = a_req[0]; gfx_addr  = a_addr[0][13:0];
            mcpu_req = a_req[1]; mcpu_addr = a_addr[1];
            scpu_req = a_req[2]; scpu_addr = a_addr[2];
        end
        gfx_req = 1'b0; mcpu_req = 1'b0; scpu_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (gfx_ack || mcpu_ack || scpu_ack) outst = 1'b0;
        end
        chk("rnd_drained", 32'(outst), 0);
        chk("rnd_max_wait_ok", 32'(max_age <= 60), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
